// File: rtl/team_03_keypad_scan.sv
// ---------------------------------------------------------------------------
// team_03_keypad_scan
//
// Scans a 4x4 matrix keypad and delivers debounced key-press events.
// Rows are driven low one at a time. The column pins are synchronized and
// then sampled at the end of each row's dwell time. Whole-matrix snapshots
// are debounced. A key code is presented on a valid/ready handshake.
//
// Ports:
//   clk        system clock (single domain)
//   nrst       synchronous active-low reset
//   en         chip enable; low forces the block idle and clears all state
//   col_in     keypad columns (async, pulled up, low = pressed on driven row)
//   row_out    keypad rows, active-low, one row low while scanning
//   row_oeb    row output enables, active-low (0 scanning, F idle)
//   key_code   pressed key = row*4 + col
//   key_valid  key_code holds an undelivered event
//   key_ready  consumer accepts the event
//   key_lost   one-cycle pulse: event dropped because the holding reg was full
// ---------------------------------------------------------------------------
module team_03_keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] row_oeb,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_lost
);

    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam int              CW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]   CNT_MAX    = CW'(DEBOUNCE_SCANS);

    // Synchronizer
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;

    // Scan sequencing
    logic          active_q, active_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    row_out_q, row_out_d;
    logic [3:0]    row_oeb_q, row_oeb_d;

    // Snapshot and debounce
    logic [11:0]   snap_q, snap_d;        // rows 0..2; row 3 arrives with the completing sample
    logic [15:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   stable_q, stable_d;

    // Holding register
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_lost_q, key_lost_d;

    // Combinational helpers
    logic          sample;
    logic          scan_done;
    logic [3:0]    col_pressed;
    logic [15:0]   full_snap;
    logic          key_event;
    logic [3:0]    key_idx;

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        sync1_d     = col_in;
        sync2_d     = sync1_q;
        active_d    = 1'b1;
        row_d       = row_q;
        dwell_d     = dwell_q;
        snap_d      = snap_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_lost_d  = 1'b0;
        key_event   = 1'b0;
        key_idx     = 4'h0;

        col_pressed = ~sync2_q;
        sample      = active_q && (dwell_q == DWELL_LAST);
        scan_done   = sample && (row_q == 2'd3);
        full_snap   = {col_pressed, snap_q};

        // The first enabled cycle only registers the row-0 drive; the dwell
        // count starts on the following cycle so row 0 gets a full SCAN_DIV.
        if (active_q) begin
            if (sample) begin
                dwell_d = '0;
                row_d   = row_q + 2'd1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end

        row_out_d = ~(4'b0001 << row_d);
        row_oeb_d = 4'h0;

        if (sample) begin
            case (row_q)
                2'd0:    snap_d[3:0]  = col_pressed;
                2'd1:    snap_d[7:4]  = col_pressed;
                2'd2:    snap_d[11:8] = col_pressed;
                default: snap_d       = snap_q;
            endcase
        end

        if (scan_done) begin
            prev_d = full_snap;
            // A zero count means no previous snapshot since reset/enable.
            if (cnt_q == '0 || full_snap != prev_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_MAX) begin
                stable_d = full_snap;
            end
            // Only a 0 -> one-hot transition is a press; multi-key states,
            // releases and multi -> single changes are ignored.
            key_event = (stable_q == 16'h0) && $onehot(stable_d);
        end

        for (int i = 0; i < 16; i++) begin
            if (stable_d[i]) begin
                key_idx = 4'(i);
            end
        end

        if (key_event) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = key_idx;
            end else begin
                key_lost_d  = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    // NOTE: reset and enable are sampled on the clock edge (synchronous);
    // en low behaves exactly like reset for every flop in the block.
    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            sync1_q     <= 4'hF;   // released-pin level
            sync2_q     <= 4'hF;
            active_q    <= 1'b0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            row_out_q   <= 4'hF;
            row_oeb_q   <= 4'hF;
            snap_q      <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_lost_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            active_q    <= active_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            row_out_q   <= row_out_d;
            row_oeb_q   <= row_oeb_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_lost_q  <= key_lost_d;
        end
    end

    assign row_out   = row_out_q;
    assign row_oeb   = row_oeb_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_lost  = key_lost_q;

endmodule

// File: tb/tb_team_03_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_team_03_keypad_scan
//
// Directed and randomized stimulus for team_03_keypad_scan with
// SCAN_DIV = 4 and DEBOUNCE_SCANS = 2. A keypad model drives col_in from
// row_out and the set of pressed keys. A scan-level reference model
// predicts row drive, events, the holding register and key_lost for every
// cycle.
// ---------------------------------------------------------------------------
module tb_team_03_keypad_scan;

    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] row_oeb;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_lost;

    team_03_keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .col_in    (col_in),
        .row_out   (row_out),
        .row_oeb   (row_oeb),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_lost  (key_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its column to its row when that row is low.
    logic [15:0] pressed;
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && pressed[r*4+c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Reference model state
    int          total = 0;
    int          bad   = 0;
    int          t     = -1;       // edges since the enabling edge
    bit          m_active = 0;
    logic [3:0]  m_row;
    logic [3:0]  m_oeb;
    logic        m_valid;
    logic [3:0]  m_code;
    logic        m_lost;
    logic [15:0] m_stable;
    logic [15:0] hist[$];
    int          lost_seen = 0;
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Scan-level model update for one clock edge.
    task automatic model_edge();
        logic [15:0] snap;
        logic [15:0] new_stable;
        bit          same;
        bit          ev;
        logic [3:0]  idx;
        ev  = 0;
        idx = 4'h0;
        if (!nrst || !en) begin
            m_active = 0;
            t        = -1;
            m_row    = 4'hF;
            m_oeb    = 4'hF;
            m_valid  = 1'b0;
            m_code   = 4'h0;
            m_lost   = 1'b0;
            m_stable = 16'h0;
            hist.delete();
        end else begin
            t        = m_active ? t + 1 : 0;
            m_active = 1;
            m_row    = 4'hF;
            m_row[(t / SD) % 4] = 1'b0;
            m_oeb    = 4'h0;
            m_lost   = 1'b0;
            if (t > 0 && t % SCAN == 0) begin
                // Keys only change at scan boundaries, so the snapshot of
                // the scan ending now is simply the current key set.
                snap = pressed;
                hist.push_back(snap);
                if (hist.size() > DB) void'(hist.pop_front());
                new_stable = m_stable;
                if (hist.size() == DB) begin
                    same = 1;
                    foreach (hist[i]) if (hist[i] != snap) same = 0;
                    if (same) new_stable = snap;
                end
                if (m_stable == 16'h0 && $countones(new_stable) == 1) begin
                    ev = 1;
                    for (int i = 0; i < 16; i++) if (new_stable[i]) idx = 4'(i);
                end
                m_stable = new_stable;
            end
            if (ev) begin
                if (!m_valid || key_ready) begin
                    m_valid = 1'b1;
                    m_code  = idx;
                end else begin
                    m_lost  = 1'b1;
                end
            end else if (m_valid && key_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: update model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("row_out",   {12'h0, row_out},   {12'h0, m_row});
        chk("row_oeb",   {12'h0, row_oeb},   {12'h0, m_oeb});
        chk("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
        chk("key_code",  {12'h0, key_code},  {12'h0, m_code});
        chk("key_lost",  {15'h0, key_lost},  {15'h0, m_lost});
        if (key_lost === 1'b1) lost_seen++;
        if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Hold a key set for n full scans, starting at a scan boundary.
    task automatic scan(input logic [15:0] keys, input int n);
        while (t % SCAN != 0) tick();
        pressed = keys;
        repeat (n) repeat (SCAN) tick();
    endtask

    task automatic ready_pulse();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        en        = 1'b0;
        key_ready = 1'b0;
        pressed   = 16'h0;

        // Reset / idle
        repeat (3) tick();
        nrst = 1'b1;
        repeat (3) tick();
        chk("idle_row_out", {12'h0, row_out}, 16'h000F);
        en = 1'b1;
        tick();
        chk("first_row", {12'h0, row_out}, 16'h000E);
        scan(16'h0, 2);

        // Single press: key 6, held 3 scans, no consumer
        scan(16'h0040, 3);
        chk("single_valid", {15'h0, key_valid}, 16'h1);
        chk("single_code",  {12'h0, key_code},  16'h6);
        ready_pulse();
        chk("single_taken", {15'h0, key_valid}, 16'h0);
        scan(16'h0040, 3);
        chk("no_repeat", {15'h0, key_valid}, 16'h0);
        scan(16'h0, 2);

        // Bounce: key 13 toggles each scan, then holds
        for (int i = 0; i < 4; i++) scan((i % 2 == 0) ? 16'h2000 : 16'h0000, 1);
        chk("bounce_quiet", {15'h0, key_valid}, 16'h0);
        scan(16'h2000, 2);
        chk("bounce_valid", {15'h0, key_valid}, 16'h1);
        chk("bounce_code",  {12'h0, key_code},  16'hD);
        ready_pulse();
        scan(16'h0, 2);

        // Multi-key: 0+5, then 5 released leaving 0
        scan(16'h0021, 3);
        scan(16'h0001, 3);
        chk("multi_none", {15'h0, key_valid}, 16'h0);
        scan(16'h0, 2);
        scan(16'h0008, 2);
        chk("multi_code", {12'h0, key_code}, 16'h3);
        ready_pulse();
        scan(16'h0, 2);

        // Overflow: key 4 then key 9 with no consumer
        lost_seen = 0;
        scan(16'h0010, 2);
        scan(16'h0, 2);
        scan(16'h0200, 2);
        scan(16'h0, 2);
        chk("ovf_lost_count", 16'(lost_seen), 16'h1);
        chk("ovf_code", {12'h0, key_code}, 16'h4);
        ready_pulse();
        chk("ovf_drained", {15'h0, key_valid}, 16'h0);

        // Enable drop with a pending code 6
        scan(16'h0040, 2);
        chk("en_pending", {15'h0, key_valid}, 16'h1);
        lost_seen = 0;
        en = 1'b0;
        tick();
        chk("en_drop_valid", {15'h0, key_valid}, 16'h0);
        chk("en_drop_row",   {12'h0, row_out},   16'h000F);
        en = 1'b1;
        tick();
        chk("en_restart_row", {12'h0, row_out}, 16'h000E);
        chk("en_no_lost", 16'(lost_seen), 16'h0);
        scan(16'h0, 2);

        // Randomized key sets and consumer behaviour
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] keys;
            case ($urandom_range(0, 3))
                0:       keys = 16'h0;
                1, 2:    keys = 16'h1 << $urandom_range(0, 15);
                default: keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            scan(keys, $urandom_range(1, 3));
        end
        rand_ready = 0;
        key_ready  = 1'b0;

        // Reset mid-operation
        scan(16'h0080, 2);
        nrst = 1'b0;
        tick();
        chk("rst_valid", {15'h0, key_valid}, 16'h0);
        chk("rst_row",   {12'h0, row_out},   16'h000F);
        nrst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
